// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: opcodes, FSM states and the
// instruction word layout {OP[1:0], ARG_HI[PAT_W-1:0], ARG_LO[TIME_W-1:0]}.
package led_seq_pkg;

    localparam logic [1:0] OP_SHOW = 2'b00;
    localparam logic [1:0] OP_JUMP = 2'b01;
    localparam logic [1:0] OP_LOOP = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'b00,
        ST_DECODE = 2'b01,
        ST_SHOW   = 2'b10,
        ST_HALT   = 2'b11
    } state_e;

    function automatic int instr_w(input int pat_w, input int time_w);
        return 2 + pat_w + time_w;
    endfunction

    function automatic int arg_hi_lsb(input int time_w);
        return time_w;
    endfunction

    function automatic int op_lsb(input int pat_w, input int time_w);
        return pat_w + time_w;
    endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Time-unit prescaler: counts 0..TICK_DIV-1 while enabled and flags the
// last count of each unit on tick_o.
module led_seq_prescaler #(
    parameter int TICK_DIV = 3125000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(32'd1);

    logic [CNT_W-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == LAST);

    // Clear wins over counting so a new SHOW always starts a fresh unit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (clr_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_q <= {CNT_W{1'b0}};
            end else begin
                cnt_q <= cnt_q + ONE;
            end
        end else begin
            cnt_q <= cnt_q;
        end
    end

endmodule

// File: rtl/led_seq_core.sv
// LED sequencer core: fetches words from a synchronous pattern ROM and runs
// SHOW / JUMP / LOOP / HALT with pause and restart control.
module led_seq_core
    import led_seq_pkg::*;
#(
    parameter int PAT_W    = 8,
    parameter int ADDR_W   = 8,
    parameter int TIME_W   = 8,
    parameter int TICK_DIV = 3125000,
    parameter int ROM_LAT  = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    output logic [ADDR_W-1:0]                   rd_addr,
    input  logic [instr_w(PAT_W, TIME_W)-1:0]   rd_data,
    input  logic                                pause,
    input  logic                                restart,
    output logic [PAT_W-1:0]                    out_pattern,
    output logic                                halted,
    output logic                                tick
);

    localparam int INSTR_W = instr_w(PAT_W, TIME_W);
    localparam logic [TIME_W-1:0] ZERO_T = {TIME_W{1'b0}};
    localparam logic [TIME_W-1:0] ONE_T  = TIME_W'(32'd1);
    localparam logic [TIME_W-1:0] TWO_T  = TIME_W'(32'd2);
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(32'd1);
    // With a combinational ROM the data is ready immediately after a pc change.
    localparam state_e ST_AFTER_PC = (ROM_LAT == 0) ? ST_DECODE : ST_WAIT;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [PAT_W-1:0]  out_pattern_q;
    logic              halted_q;
    logic              loop_active_q;
    logic [TIME_W-1:0] loop_rem_q;
    logic [TIME_W-1:0] time_cnt_q;
    logic [TIME_W-1:0] dur_q;
    logic [1:0]        wait_cnt_q;

    logic [1:0]        op_s;
    logic [PAT_W-1:0]  arg_hi_s;
    logic [TIME_W-1:0] arg_lo_s;
    logic [ADDR_W-1:0] target_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic              wait_done_s;
    logic              presc_en_s;
    logic              presc_clr_s;
    logic              presc_tick_s;

    assign op_s        = rd_data[op_lsb(PAT_W, TIME_W) +: 2];
    assign arg_hi_s    = rd_data[arg_hi_lsb(TIME_W) +: PAT_W];
    assign arg_lo_s    = rd_data[TIME_W-1:0];
    assign target_s    = arg_hi_s[ADDR_W-1:0];
    assign pc_inc_s    = pc_q + ONE_A;
    assign wait_done_s = ({30'd0, wait_cnt_q} + 32'd1) >= 32'(ROM_LAT);

    assign presc_en_s  = (state_q == ST_SHOW) && !pause && !restart;
    assign presc_clr_s = restart || (state_q != ST_SHOW);

    led_seq_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (presc_clr_s),
        .en_i   (presc_en_s),
        .tick_o (presc_tick_s)
    );

    assign rd_addr     = pc_q;
    assign out_pattern = out_pattern_q;
    assign halted      = halted_q;
    assign tick        = presc_tick_s;

    // Sequencer FSM: restart beats pause, and pause freezes everything else.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_WAIT;
            pc_q          <= {ADDR_W{1'b0}};
            out_pattern_q <= {PAT_W{1'b0}};
            halted_q      <= 1'b0;
            loop_active_q <= 1'b0;
            loop_rem_q    <= ZERO_T;
            time_cnt_q    <= ZERO_T;
            dur_q         <= ZERO_T;
            wait_cnt_q    <= 2'd0;
        end else if (restart) begin
            state_q       <= ST_WAIT;
            pc_q          <= {ADDR_W{1'b0}};
            halted_q      <= 1'b0;
            loop_active_q <= 1'b0;
            loop_rem_q    <= ZERO_T;
            time_cnt_q    <= ZERO_T;
            wait_cnt_q    <= 2'd0;
        end else if (!pause) begin
            case (state_q)
                ST_WAIT: begin
                    if (wait_done_s) begin
                        state_q    <= ST_DECODE;
                        wait_cnt_q <= 2'd0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 2'd1;
                    end
                end
                ST_DECODE: begin
                    wait_cnt_q <= 2'd0;
                    case (op_s)
                        OP_SHOW: begin
                            out_pattern_q <= arg_hi_s;
                            if (arg_lo_s == ZERO_T) begin
                                pc_q    <= pc_inc_s;
                                state_q <= ST_AFTER_PC;
                            end else begin
                                dur_q      <= arg_lo_s;
                                time_cnt_q <= ZERO_T;
                                state_q    <= ST_SHOW;
                            end
                        end
                        OP_JUMP: begin
                            pc_q    <= target_s;
                            state_q <= ST_AFTER_PC;
                        end
                        OP_LOOP: begin
                            state_q <= ST_AFTER_PC;
                            // loop_rem counts the jumps still owed after this one.
                            if (!loop_active_q) begin
                                if (arg_lo_s >= TWO_T) begin
                                    loop_active_q <= 1'b1;
                                    loop_rem_q    <= arg_lo_s - TWO_T;
                                    pc_q          <= target_s;
                                end else begin
                                    pc_q <= pc_inc_s;
                                end
                            end else if (loop_rem_q == ZERO_T) begin
                                loop_active_q <= 1'b0;
                                pc_q          <= pc_inc_s;
                            end else begin
                                loop_rem_q <= loop_rem_q - ONE_T;
                                pc_q       <= target_s;
                            end
                        end
                        OP_HALT: begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end
                        default: begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end
                    endcase
                end
                ST_SHOW: begin
                    if (presc_tick_s) begin
                        time_cnt_q <= time_cnt_q + ONE_T;
                        if ((time_cnt_q + ONE_T) == dur_q) begin
                            pc_q    <= pc_inc_s;
                            state_q <= ST_AFTER_PC;
                        end
                    end
                end
                ST_HALT: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_seq_core.sv
// Scoreboard bench for led_seq_core: an instruction-level model predicts output
// changes and tick pulses in "effective" clock edges (edges not frozen by pause).
module tb_led_seq_core;

    localparam int PAT_W  = 8;
    localparam int ADDR_W = 8;
    localparam int TIME_W = 8;
    localparam int TD     = 4;
    localparam int RL     = 1;
    localparam int IW     = 2 + PAT_W + TIME_W;

    localparam logic [1:0] T_SHOW = 2'b00;
    localparam logic [1:0] T_JUMP = 2'b01;
    localparam logic [1:0] T_LOOP = 2'b10;
    localparam logic [1:0] T_HALT = 2'b11;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              pause = 1'b0;
    logic              restart = 1'b0;
    logic [ADDR_W-1:0] rd_addr;
    logic [IW-1:0]     rd_data;
    logic [PAT_W-1:0]  out_pattern;
    logic              halted;
    logic              tick;

    logic [IW-1:0]     rom [256];

    int checks = 0;
    int errors = 0;
    int ecyc;
    int wcyc;
    bit mon_en = 1'b0;
    int last_pc_wall = -1;

    typedef struct {
        int t;
        int pc;
        int pat;
        bit h;
    } ev_t;

    ev_t exp_q[$];
    int  tick_q[$];
    int  m_last_pc, m_last_pat, m_pat;
    bit  m_last_h;

    logic [ADDR_W-1:0] prev_pc;
    logic [PAT_W-1:0]  prev_pat;
    logic              prev_h;

    led_seq_core #(
        .PAT_W    (PAT_W),
        .ADDR_W   (ADDR_W),
        .TIME_W   (TIME_W),
        .TICK_DIV (TD),
        .ROM_LAT  (RL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .pause       (pause),
        .restart     (restart),
        .out_pattern (out_pattern),
        .halted      (halted),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) rd_data <= rom[rd_addr];

    // Wall and effective edge counters since reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ecyc <= 0;
            wcyc <= 0;
        end else begin
            wcyc <= wcyc + 1;
            if (!pause || restart) ecyc <= ecyc + 1;
        end
    end

    function automatic logic [IW-1:0] mk(input logic [1:0] op, input int hi, input int lo);
        logic [7:0] h8, l8;
        h8 = hi[7:0];
        l8 = lo[7:0];
        return {op, h8, l8};
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endfunction

    function automatic void emit(input int t, input int pc, input int pat, input bit h);
        ev_t e;
        if (pc != m_last_pc || pat != m_last_pat || h != m_last_h) begin
            e.t = t; e.pc = pc; e.pat = pat; e.h = h;
            exp_q.push_back(e);
            m_last_pc = pc; m_last_pat = pat; m_last_h = h;
        end
    endfunction

    // Instruction-level interpreter: each word costs RL+1 edges, SHOW adds d*TD.
    task automatic model_run(input int p0, input int horizon, output int t_halt);
        int t, pc, td, hi, lo, owed;
        logic [1:0] op;
        bit active, done;
        t = p0; pc = 0; active = 1'b0; owed = 0; t_halt = -1; done = 1'b0;
        while (!done) begin
            td = t + RL + 1;
            op = rom[pc][IW-1:IW-2];
            hi = int'(rom[pc][15:8]);
            lo = int'(rom[pc][7:0]);
            if (td > horizon) begin
                done = 1'b1;
            end else begin
                case (op)
                    T_SHOW: begin
                        m_pat = hi;
                        if (lo == 0) begin
                            pc = (pc + 1) % 256;
                            emit(td, pc, m_pat, 1'b0);
                            t = td;
                        end else begin
                            emit(td, pc, m_pat, 1'b0);
                            for (int k = 1; k <= lo; k++)
                                if (td + k * TD <= horizon) tick_q.push_back(td + k * TD);
                            t = td + lo * TD;
                            if (t > horizon) done = 1'b1;
                            else begin
                                pc = (pc + 1) % 256;
                                emit(t, pc, m_pat, 1'b0);
                            end
                        end
                    end
                    T_JUMP: begin
                        pc = hi;
                        emit(td, pc, m_pat, 1'b0);
                        t = td;
                    end
                    T_LOOP: begin
                        if (!active && lo >= 2) begin
                            active = 1'b1; owed = lo - 2; pc = hi;
                        end else if (active && owed > 0) begin
                            owed--; pc = hi;
                        end else begin
                            active = 1'b0; pc = (pc + 1) % 256;
                        end
                        emit(td, pc, m_pat, 1'b0);
                        t = td;
                    end
                    default: begin
                        emit(td, pc, m_pat, 1'b1);
                        t_halt = td;
                        done = 1'b1;
                    end
                endcase
            end
        end
    endtask

    task automatic mon_step();
        ev_t e;
        int et;
        if (!rst || !mon_en) begin
            prev_pc = rd_addr; prev_pat = out_pattern; prev_h = halted;
        end else begin
            if (pause) chk("tick_in_pause", {31'd0, tick}, 32'd0);
            if (tick === 1'b1) begin
                checks++;
                if (tick_q.size() == 0) begin
                    errors++;
                    $display("FAIL tick: pulse before edge %0d, none required", ecyc + 1);
                end else begin
                    et = tick_q.pop_front();
                    if (et != ecyc + 1) begin
                        errors++;
                        $display("FAIL tick: pulse before edge %0d, required before edge %0d", ecyc + 1, et);
                    end
                end
            end
            if (rd_addr !== prev_pc || out_pattern !== prev_pat || halted !== prev_h) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL event: edge %0d pc %0d pat %02h halted %0b, no change required",
                             ecyc, rd_addr, out_pattern, halted);
                end else begin
                    e = exp_q.pop_front();
                    if (e.t != ecyc || rd_addr !== e.pc[7:0] || out_pattern !== e.pat[7:0] || halted !== e.h) begin
                        errors++;
                        $display("FAIL event: got edge %0d pc %0d pat %02h halted %0b, required edge %0d pc %0d pat %02h halted %0b",
                                 ecyc, rd_addr, out_pattern, halted, e.t, e.pc, e.pat, e.h);
                    end
                end
                if (rd_addr !== prev_pc) last_pc_wall = wcyc;
                prev_pc = rd_addr; prev_pat = out_pattern; prev_h = halted;
            end
        end
    endtask

    task automatic reset_dut();
        mon_en = 1'b0; pause = 1'b0; restart = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("reset_rd_addr", {24'd0, rd_addr}, 32'd0);
        chk("reset_pattern", {24'd0, out_pattern}, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        exp_q.delete(); tick_q.delete();
        m_last_pc = 0; m_last_pat = 0; m_last_h = 1'b0; m_pat = 0;
        last_pc_wall = -1;
    endtask

    task automatic release_dut();
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1'b1;
    endtask

    // mode 0: no pause, 1: random pause, 2: one 7-edge pause burst
    task automatic drive_until(input int horizon, input int mode);
        int w;
        w = 0;
        while (ecyc < horizon && w < horizon * 3 + 50) begin
            case (mode)
                0: pause = 1'b0;
                1: pause = ($urandom_range(0, 3) == 0);
                2: pause = (w >= 4 && w < 11);
                default: pause = 1'b0;
            endcase
            @(posedge clk); #1;
            w++;
        end
        pause = 1'b1;
        checks++;
        if (ecyc < horizon) begin
            errors++;
            $display("FAIL timeout: reached edge %0d, required edge %0d", ecyc, horizon);
        end
    endtask

    task automatic end_check(input string name);
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0 || tick_q.size() != 0) begin
            errors++;
            $display("FAIL %s leftovers: %0d events %0d ticks outstanding, required 0 and 0",
                     name, exp_q.size(), tick_q.size());
        end
        mon_en = 1'b0;
    endtask

    task automatic run_prog(input string name, input int horizon, input int mode);
        int th;
        model_run(0, horizon, th);
        release_dut();
        drive_until((th >= 0) ? th + 2 : horizon, mode);
        end_check(name);
    endtask

    task automatic fill_halt();
        for (int a = 0; a < 256; a++) rom[a] = mk(T_HALT, 0, 0);
    endtask

    initial begin
        int th, th2, r, op_i, hi, lo;
        int nvals[3];
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        // show / show-zero / jump back
        reset_dut();
        fill_halt();
        rom[0] = mk(T_SHOW, 8'hA5, 3);
        rom[1] = mk(T_SHOW, 8'h0F, 0);
        rom[2] = mk(T_JUMP, 0, 0);
        run_prog("show_jump", 60, 0);

        // counted loop with N = 3, 0, 1
        nvals[0] = 3; nvals[1] = 0; nvals[2] = 1;
        for (int i = 0; i < 3; i++) begin
            reset_dut();
            fill_halt();
            rom[0] = mk(T_SHOW, 8'h01, 1);
            rom[1] = mk(T_LOOP, 0, nvals[i]);
            rom[2] = mk(T_HALT, 0, 0);
            run_prog("loop", 300, 1);
            chk("loop_halt_pc", {24'd0, rd_addr}, 32'd2);
        end

        // pause burst in the middle of a two-unit SHOW
        reset_dut();
        fill_halt();
        rom[0] = mk(T_SHOW, 8'h3C, 2);
        rom[1] = mk(T_HALT, 0, 0);
        run_prog("pause_burst", 100, 2);
        chk("pause_show_len", last_pc_wall, 32'd17);

        // restart while halted and paused
        reset_dut();
        fill_halt();
        rom[0] = mk(T_SHOW, 8'h01, 1);
        rom[1] = mk(T_LOOP, 0, 3);
        rom[2] = mk(T_HALT, 0, 0);
        model_run(0, 300, th);
        release_dut();
        drive_until(th + 3, 1);
        restart = 1'b1;
        r = ecyc + 1;
        emit(r, 0, m_pat, 1'b0);
        model_run(r, r + 300, th2);
        @(posedge clk); #1;
        restart = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        drive_until(th2 + 2, 1);
        end_check("restart");

        // pc wrap across the full address space
        reset_dut();
        for (int a = 0; a < 256; a++) rom[a] = mk(T_SHOW, a, 0);
        run_prog("pc_wrap", 530, 1);

        // random programs in the low 16 words
        for (int n = 0; n < 6; n++) begin
            reset_dut();
            fill_halt();
            for (int a = 0; a < 16; a++) begin
                r = $urandom_range(0, 99);
                op_i = (r < 50) ? 0 : (r < 62) ? 1 : (r < 85) ? 2 : 3;
                hi = (op_i == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
                lo = (op_i == 2) ? $urandom_range(0, 4) : $urandom_range(0, 3);
                rom[a] = mk(op_i[1:0], hi, lo);
            end
            run_prog("random", 300, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_seq_core.md
Name: led_seq_core

Overview:
Parametrised LED sequencer core, successor to the current fixed 8-bit LED CPU. It fetches instruction words from an external synchronous ROM and drives an LED pattern for a programmed number of time units. It adds opcodes for show, jump, counted loop and halt, plus pause and restart control. It sits between the pattern ROM and the board LED pins.

Parameters:
PAT_W, 8, LED pattern width; also the width of the ARG_HI field.
ADDR_W, 8, ROM address width; must satisfy ADDR_W <= PAT_W.
TIME_W, 8, duration/count field width (ARG_LO).
TICK_DIV, 3125000, clock cycles per time unit (50 MHz / 16); must be >= 1.
ROM_LAT, 1, ROM read latency in cycles (0..3).
Derived: INSTR_W = 2 + PAT_W + TIME_W; word layout = {OP[1:0], ARG_HI[PAT_W-1:0], ARG_LO[TIME_W-1:0]}.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
rd_addr  out  ADDR_W  ROM address (registered, equals pc)
rd_data  in  INSTR_W  ROM data, valid ROM_LAT cycles after rd_addr changes
pause  in  1  level; freezes the FSM, prescaler and counters; outputs hold
restart  in  1  synchronous pulse; pc=0, loop state cleared, goes to WAIT
out_pattern  out  PAT_W  LED drive (registered)
halted  out  1  high while in HALT state
tick  out  1  one-cycle pulse at each time-unit boundary during SHOW

Behaviour:
- Reset (rst=0, async): pc=0, out_pattern=0, halted=0, tick=0, loop_active=0, loop_rem=0, prescaler=0, time_cnt=0, state=WAIT.
- States: WAIT, DECODE, SHOW, HALT.
- WAIT: stays ROM_LAT cycles, counted from the last pc change, then DECODE. With ROM_LAT=0, WAIT is skipped: a pc change goes straight to DECODE.
- DECODE samples rd_data. Opcodes:
  - OP=00 SHOW: out_pattern<=ARG_HI. If ARG_LO=0: pc+1 and go to WAIT. Else clear prescaler and time_cnt, go to SHOW.
  - OP=01 JUMP: pc<=ARG_HI[ADDR_W-1:0], go to WAIT. out_pattern unchanged.
  - OP=10 LOOP (target=ARG_HI[ADDR_W-1:0], N=ARG_LO):
    - loop_active=0, N<=1: fall through (pc+1).
    - loop_active=0, N>=2: loop_active=1, loop_rem=N-2, jump to target.
    - loop_active=1, loop_rem=0: loop_active=0, fall through.
    - loop_active=1, loop_rem>0: loop_rem-1, jump to target.
    - Result: the body executes exactly N times (at least once). One loop level only; a nested LOOP shares the same counter (documented restriction, not detected).
  - OP=11 HALT: state=HALT, halted=1, out_pattern held. Only restart or reset leaves HALT.
- SHOW:
  - Prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0, tick=1 for that cycle, and time_cnt+1.
  - When time_cnt reaches ARG_LO (latched at DECODE): pc+1, go to WAIT.
  - SHOW occupies exactly ARG_LO*TICK_DIV cycles.
- pc+1 wraps modulo 2^ADDR_W (2^ADDR_W-1 -> 0).
- Overhead per instruction = ROM_LAT+1 cycles (WAIT + DECODE).
- pause=1: no state, pc, prescaler or time_cnt change; tick=0. Resumes exactly where it stopped.
- restart:
  - Priority over pause and over all state logic.
  - pc=0, loop cleared, halted=0, state=WAIT; out_pattern holds until the next SHOW.
  - restart while rst=0 has no effect.
- JUMP-to-self is legal and spins with period ROM_LAT+1; no lockup detection.

Decomposition:
- Shared package led_seq_pkg: opcode constants OP_SHOW=2'b00, OP_JUMP=2'b01, OP_LOOP=2'b10, OP_HALT=2'b11; state encoding; INSTR_W derivation and field-slice helpers.
- One sub-module, led_seq_prescaler: TICK_DIV counter with clear and enable inputs and a tick output. Everything else lives in the core.

Test Plan (TICK_DIV=4, ROM_LAT=1, defaults otherwise):
- Reset mid-SHOW: assert rst=0 asynchronously -> rd_addr=0, out_pattern=0, halted=0 immediately; after release, first DECODE at cycle 2.
- ROM {SHOW 0xA5 d=3, SHOW 0x0F d=0, JUMP 0} -> 0xA5 held 12 cycles; 0x0F present for 1 DECODE cycle; pc sequence 0,1,2,0; tick pulses every 4 cycles during SHOW only.
- ROM {SHOW 0x01 d=1, LOOP tgt=0 N=3, HALT} -> exactly three 0x01 SHOW periods, then halted=1 at pc=2. Repeat with N=0 and N=1 -> one period each.
- pause asserted for 7 cycles in the middle of a d=2 SHOW -> SHOW lasts 8+7 cycles; tick low and pc stable during the pause.
- restart pulse while halted=1 and pause=1 -> halted=0, pc=0, execution resumes from address 0 on the next cycle the pause is released.
- ADDR_W=4, 16 consecutive SHOW d=0 words -> pc wraps 15->0 with no glitch on rd_addr.
